// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for alu_seq.
package alu_seq_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
  localparam logic [SEL_W-1:0] OP_NOP = 3'b100;
  localparam logic [SEL_W-1:0] OP_MUL = 3'b101;
  localparam logic [SEL_W-1:0] OP_XOR = 3'b110;
  localparam logic [SEL_W-1:0] OP_SLT = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// o_done_c / o_product_c are combinational and valid on the final iteration
// cycle so the parent can register the full product on that edge.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_op_a,
  input  logic [WIDTH-1:0]   i_op_b,
  output logic               o_done_c,
  output logic [2*WIDTH-1:0] o_product_c
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [RW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [RW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [RW-1:0]    w_acc_nxt;
  logic             w_last;

  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : RW'(0));
  assign w_last      = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_done_c    = w_last;
  assign o_product_c = w_acc_nxt;

  // Load operands on start, then consume one multiplier bit per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= RW'(i_op_a);
      r_mplier <= i_op_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, optional multi-cycle multiply.
// Build option: define ALU_SEQ_MUL_EN to implement opcode 101 (MUL);
// otherwise opcode 101 behaves as NOP.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  input  logic [SEL_W-1:0]   selector,
  output logic [2*WIDTH-1:0] Result_op,
  output logic               Zeroflag,
  output logic               Carryflag,
  output logic               o_valid
);

  localparam int unsigned RW = 2 * WIDTH;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic             w_wr_en;
  logic [RW-1:0]    w_wr_res;
  logic             w_wr_carry;
  logic             w_pulse;
`ifdef ALU_SEQ_MUL_EN
  logic             w_mul_start;
  logic             w_mul_done;
  logic [RW-1:0]    w_mul_product;
`endif

  assign w_accept = i_valid && o_ready;
  assign w_sum    = {1'b0, i_op1} + {1'b0, i_op2};
  assign w_diff   = i_op1 - i_op2;
  assign w_lt     = (i_op1 < i_op2);

`ifdef ALU_SEQ_MUL_EN
  assign w_mul_start = w_accept && (selector == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_mul_start),
    .i_op_a      (i_op1),
    .i_op_b      (i_op2),
    .o_done_c    (w_mul_done),
    .o_product_c (w_mul_product)
  );
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: only an accepted MUL leaves IDLE; MUL returns when done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_start) w_state_nxt = ST_MUL;
`endif
      end
      ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_done) w_state_nxt = ST_IDLE;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state plus result-write selection.
  always_comb begin
    o_ready    = (r_state == ST_IDLE);
    w_wr_en    = 1'b0;
    w_wr_res   = '0;
    w_wr_carry = 1'b0;
    w_pulse    = 1'b0;
    if (w_accept) begin
      w_pulse = 1'b1;
      case (selector)
        OP_ADD: begin w_wr_en = 1'b1; w_wr_res = RW'(w_sum);  w_wr_carry = w_sum[WIDTH]; end
        OP_SUB: begin w_wr_en = 1'b1; w_wr_res = RW'(w_diff); w_wr_carry = w_lt;         end
        OP_AND: begin w_wr_en = 1'b1; w_wr_res = RW'(i_op1 & i_op2); end
        OP_OR:  begin w_wr_en = 1'b1; w_wr_res = RW'(i_op1 | i_op2); end
        OP_XOR: begin w_wr_en = 1'b1; w_wr_res = RW'(i_op1 ^ i_op2); end
        OP_SLT: begin w_wr_en = 1'b1; w_wr_res = RW'(w_lt);   w_wr_carry = w_lt;         end
`ifdef ALU_SEQ_MUL_EN
        OP_MUL: w_pulse = 1'b0;
`endif
        default: ;
      endcase
    end
`ifdef ALU_SEQ_MUL_EN
    if (w_mul_done) begin
      w_wr_en  = 1'b1;
      w_wr_res = w_mul_product;
      w_pulse  = 1'b1;
    end
`endif
  end

  // Result/flag registers hold between writes; o_valid is a one-cycle pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      Result_op <= '0;
      Zeroflag  <= 1'b0;
      Carryflag <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= w_pulse;
      if (w_wr_en) begin
        Result_op <= w_wr_res;
        Zeroflag  <= (w_wr_res == '0);
        Carryflag <= w_wr_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16), either MUL build.
module tb_alu_seq;

  localparam int unsigned WIDTH = 16;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic              ready;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic [2:0]        sel;
  logic [31:0]       result;
  logic              zf;
  logic              cf;
  logic              ovalid;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .o_ready   (ready),
    .i_op1     (op1),
    .i_op2     (op2),
    .selector  (sel),
    .Result_op (result),
    .Zeroflag  (zf),
    .Carryflag (cf),
    .o_valid   (ovalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present one request, let it be accepted, drop valid.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    sel = op; op1 = a; op2 = b; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] r, input logic z, input logic c);
    check({tag, ".valid"}, 32'(ovalid), 32'd1);
    check({tag, ".res"}, result, r);
    check({tag, ".zf"}, 32'(zf), 32'(z));
    check({tag, ".cf"}, 32'(cf), 32'(c));
  endtask

  initial begin
    int lat;
    int low;
    int ready_drop;
    rst_n = 1'b0; valid = 1'b0; op1 = '0; op2 = '0; sel = 3'b000;
    #12;
    check("rst.res", result, 32'd0);
    check("rst.zf", 32'(zf), 32'd0);
    check("rst.cf", 32'(cf), 32'd0);
    check("rst.valid", 32'(ovalid), 32'd0);
    check("rst.ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'b000, 16'd10, 16'd22);
    expect_res("add1", 32'd32, 1'b0, 1'b0);
    @(negedge clk);
    check("add1.pulse_end", 32'(ovalid), 32'd0);

    send(3'b000, 16'hFFFF, 16'd1);
    expect_res("add_carry", 32'h0001_0000, 1'b0, 1'b1);

    send(3'b001, 16'd20, 16'd20);
    expect_res("sub_zero", 32'd0, 1'b1, 1'b0);

    send(3'b001, 16'd5, 16'd7);
    expect_res("sub_borrow", 32'h0000_FFFE, 1'b0, 1'b1);

    // Back-to-back AND, OR, NOP on consecutive edges.
    sel = 3'b010; op1 = 16'd100; op2 = 16'd125; valid = 1'b1;
    @(negedge clk);
    expect_res("and", 32'd100, 1'b0, 1'b0);
    sel = 3'b011; op1 = 16'd90; op2 = 16'd30;
    @(negedge clk);
    expect_res("or", 32'd94, 1'b0, 1'b0);
    sel = 3'b100; op1 = 16'd34; op2 = 16'd45;
    @(negedge clk);
    valid = 1'b0;
    expect_res("nop", 32'd94, 1'b0, 1'b0);
    @(negedge clk);
    check("nop.pulse_end", 32'(ovalid), 32'd0);

    send(3'b111, 16'd9, 16'd3);
    expect_res("slt_false", 32'd0, 1'b1, 1'b0);
    send(3'b111, 16'd3, 16'd9);
    expect_res("slt_true", 32'd1, 1'b0, 1'b1);
    send(3'b110, 16'h00F0, 16'h0FF0);
    expect_res("xor", 32'h0000_0F00, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    // MUL with an ADD held pending through the busy window.
    send(3'b101, 16'd300, 16'd250);
    check("mul.accept_novalid", 32'(ovalid), 32'd0);
    sel = 3'b000; op1 = 16'd7; op2 = 16'd8; valid = 1'b1;
    lat = 0; low = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (!ready) low++;
      if (ovalid) lat = k;
      else if (k > 1 && result !== 32'h0000_0F00) check("mul.hold", result, 32'h0000_0F00);
      if (lat == 0) @(negedge clk);
    end
    check("mul.latency", 32'(lat), 32'd17);
    check("mul.busy_cycles", 32'(low), 32'd16);
    expect_res("mul", 32'd75000, 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    expect_res("add_after_mul", 32'd15, 1'b0, 1'b0);
    @(negedge clk);

    // Abort a MUL with reset eight cycles in.
    send(3'b101, 16'd300, 16'd250);
    repeat (7) @(negedge clk);
    check("mul8.ready", 32'(ready), 32'd0);
`else
    // Opcode 101 degenerates to NOP.
    sel = 3'b101; op1 = 16'd3; op2 = 16'd4; valid = 1'b1;
    ready_drop = 0;
    @(negedge clk);
    valid = 1'b0;
    if (!ready) ready_drop = 1;
    expect_res("op101_nop", 32'h0000_0F00, 1'b0, 1'b0);
    @(negedge clk);
    if (!ready) ready_drop = 1;
    check("op101.ready_stays", 32'(ready_drop), 32'd0);
    check("op101.pulse_end", 32'(ovalid), 32'd0);
`endif

    rst_n = 1'b0;
    #1;
    check("arst.res", result, 32'd0);
    check("arst.zf", 32'(zf), 32'd0);
    check("arst.cf", 32'(cf), 32'd0);
    check("arst.ready", 32'(ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("arst.novalid", 32'(ovalid), 32'd0);
    end
    rst_n = 1'b1;
    send(3'b000, 16'd1, 16'd1);
    expect_res("add_post_rst", 32'd2, 1'b0, 1'b0);
    repeat (20) begin
      @(negedge clk);
      if (ovalid) check("post_rst.spurious_valid", 32'(ovalid), 32'd0);
    end
    check("post_rst.res_hold", result, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
